// File: rtl/de_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : de_exe_stage
// Brief    : Decode-to-execute issue stage with a one-entry slot, operand
//            forwarding, load-use bubbles and branch flush. Optional bubble
//            counter is enabled by defining DE_EXE_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module de_exe_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_de,
    input  logic [31:0]     instr_de,
    input  logic [XLEN-1:0] pc_de,
    input  logic [XLEN-1:0] rs1_data_de,
    input  logic [XLEN-1:0] rs2_data_de,
    input  logic            stall,
    input  logic            hazard_a,
    input  logic            hazard_b,
    input  logic [XLEN-1:0] data_a_mgr,
    input  logic [XLEN-1:0] data_b_mgr,
    input  logic            flush,
    output logic            stall_de,
    output logic            valid_exe,
    output logic [31:0]     instr_exe,
    output logic [XLEN-1:0] pc_exe,
    output logic [XLEN-1:0] op_a_exe,
    output logic [XLEN-1:0] op_b_exe,
    output logic [31:0]     stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;

    logic            valid_exe_q, valid_exe_d;
    logic [31:0]     instr_exe_q, instr_exe_d;
    logic [XLEN-1:0] pc_exe_q, pc_exe_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;

    logic            w_stall_eff;
    logic            w_issue;
    logic            w_capture;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;

    // A stall only matters when the slot actually holds an instruction.
    assign w_stall_eff = stall & valid_q;

    // x0 beats forwarding: the hazard manager does not mask register zero.
    assign w_op_a = (instr_q[19:15] == 5'd0) ? '0 : (hazard_a ? data_a_mgr : rs1_q);
    assign w_op_b = (instr_q[24:20] == 5'd0) ? '0 : (hazard_b ? data_b_mgr : rs2_q);

    assign stall_de = (state_q == S_HOLD);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        valid_exe_d = 1'b0;
        instr_exe_d = NOP_INSTR;
        pc_exe_d    = pc_exe_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        w_issue     = 1'b0;
        w_capture   = 1'b0;

        if (flush) begin
            state_d = S_EMPTY;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (valid_de) begin
                        w_capture = 1'b1;
                        state_d   = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_stall_eff) begin
                        state_d = S_HOLD;
                    end else begin
                        w_issue = 1'b1;
                        if (valid_de) begin
                            w_capture = 1'b1;
                            state_d   = S_ISSUE;
                        end else begin
                            valid_d = 1'b0;
                            state_d = S_EMPTY;
                        end
                    end
                end
                S_HOLD: begin
                    // Decode is held off this edge, so nothing new is captured.
                    if (!w_stall_eff) begin
                        w_issue = 1'b1;
                        valid_d = 1'b0;
                        state_d = S_EMPTY;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = S_EMPTY;
                end
            endcase
        end

        if (w_capture) begin
            valid_d = 1'b1;
            instr_d = instr_de;
            pc_d    = pc_de;
            rs1_d   = rs1_data_de;
            rs2_d   = rs2_data_de;
        end

        if (w_issue) begin
            valid_exe_d = 1'b1;
            instr_exe_d = instr_q;
            pc_exe_d    = pc_q;
            op_a_d      = w_op_a;
            op_b_d      = w_op_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_EMPTY;
            valid_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            valid_exe_q <= 1'b0;
            instr_exe_q <= NOP_INSTR;
            pc_exe_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            valid_exe_q <= valid_exe_d;
            instr_exe_q <= instr_exe_d;
            pc_exe_q    <= pc_exe_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
        end
    end

    assign valid_exe = valid_exe_q;
    assign instr_exe = instr_exe_q;
    assign pc_exe    = pc_exe_q;
    assign op_a_exe  = op_a_q;
    assign op_b_exe  = op_b_q;

`ifdef DE_EXE_STALL_CNT_EN
    logic        w_stall_bubble;
    logic [31:0] stall_cnt_q;

    // Only stall-induced bubbles count; flush and empty-slot bubbles do not.
    assign w_stall_bubble = w_stall_eff & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (w_stall_bubble && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_de_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_de_exe_stage
// Brief    : Randomized scoreboard bench for de_exe_stage with a queue-based
//            reference model of the issue slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_de_exe_stage;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic            clk;
    logic            rst;
    logic            valid_de;
    logic [31:0]     instr_de;
    logic [XLEN-1:0] pc_de, rs1_data_de, rs2_data_de;
    logic            stall, hazard_a, hazard_b, flush;
    logic [XLEN-1:0] data_a_mgr, data_b_mgr;
    logic            stall_de, valid_exe;
    logic [31:0]     instr_exe;
    logic [XLEN-1:0] pc_exe, op_a_exe, op_b_exe;
    logic [31:0]     stall_cnt;

    de_exe_stage #(.XLEN(XLEN), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .valid_de(valid_de), .instr_de(instr_de),
        .pc_de(pc_de), .rs1_data_de(rs1_data_de), .rs2_data_de(rs2_data_de),
        .stall(stall), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .data_a_mgr(data_a_mgr), .data_b_mgr(data_b_mgr), .flush(flush),
        .stall_de(stall_de), .valid_exe(valid_exe), .instr_exe(instr_exe),
        .pc_exe(pc_exe), .op_a_exe(op_a_exe), .op_b_exe(op_b_exe),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: a pending-instruction queue of depth one plus a
    // "decode held off" flag and a bubble tally.
    exp_t        m_slot[$];
    logic [XLEN-1:0] m_r1, m_r2;
    bit          m_hold;
    logic [31:0] m_cnt;
    logic [XLEN-1:0] last_pc, last_a, last_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (!rst) begin
                last_pc = '0; last_a = '0; last_b = '0;
                check("reset_valid_exe", {31'd0, valid_exe}, 32'd0);
                check("reset_instr_exe", instr_exe, NOP);
            end else if (valid_exe) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got valid_exe=1 expected 0 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("instr_exe", instr_exe, e.instr);
                    check("pc_exe", pc_exe, e.pc);
                    check("op_a_exe", op_a_exe, e.a);
                    check("op_b_exe", op_b_exe, e.b);
                    last_pc = e.pc; last_a = e.a; last_b = e.b;
                end
            end else begin
                check("missed_issue", sb_q.size(), 32'd0);
                check("bubble_instr", instr_exe, NOP);
                check("bubble_pc_hold", pc_exe, last_pc);
                check("bubble_a_hold", op_a_exe, last_a);
                check("bubble_b_hold", op_b_exe, last_b);
            end
        end
    end

    task automatic model_reset();
        m_slot.delete();
        sb_q.delete();
        m_hold = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                         input bit st, input bit ha, input bit hb,
                         input logic [XLEN-1:0] da, input logic [XLEN-1:0] db, input bit fl);
        exp_t s;
        exp_t o;
        logic [31:0] exp_cnt;
        bit was_hold;
        @(negedge clk);
        check("stall_de", {31'd0, stall_de}, {31'd0, m_hold});
`ifdef DE_EXE_STALL_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'd0;
`endif
        check("stall_cnt", stall_cnt, exp_cnt);
        valid_de = v; instr_de = ins; pc_de = pc; rs1_data_de = r1; rs2_data_de = r2;
        stall = st; hazard_a = ha; hazard_b = hb; data_a_mgr = da; data_b_mgr = db; flush = fl;

        if (fl) begin
            m_slot.delete();
            m_hold = 1'b0;
        end else if (m_slot.size() != 0 && st) begin
            m_hold = 1'b1;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (m_slot.size() != 0) begin
            s = m_slot.pop_front();
            o.instr = s.instr;
            o.pc    = s.pc;
            o.a     = (s.instr[19:15] == 5'd0) ? '0 : (ha ? da : m_r1);
            o.b     = (s.instr[24:20] == 5'd0) ? '0 : (hb ? db : m_r2);
            sb_q.push_back(o);
            was_hold = m_hold;
            m_hold = 1'b0;
            if (!was_hold && v) begin
                s.instr = ins; s.pc = pc; s.a = '0; s.b = '0;
                m_slot.push_back(s); m_r1 = r1; m_r2 = r2;
            end
        end else if (v) begin
            s.instr = ins; s.pc = pc; s.a = '0; s.b = '0;
            m_slot.push_back(s); m_r1 = r1; m_r2 = r2;
        end
    endtask

    task automatic idle(input bit st, input bit fl);
        drive(1'b0, 32'h0, '0, '0, '0, st, 1'b0, 1'b0, '0, '0, fl);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid_exe", {31'd0, valid_exe}, 32'd0);
        check("arst_instr_exe", instr_exe, NOP);
        check("arst_pc_exe", pc_exe, 32'd0);
        check("arst_op_a", op_a_exe, 32'd0);
        check("arst_op_b", op_b_exe, 32'd0);
        check("arst_stall_de", {31'd0, stall_de}, 32'd0);
        check("arst_stall_cnt", stall_cnt, 32'd0);
        valid_de = 1'b0; stall = 1'b0; flush = 1'b0; hazard_a = 1'b0; hazard_b = 1'b0;
        repeat (n) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_cycle();
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(3) == 0) ins[19:15] = 5'd0;
        if ($urandom_range(3) == 0) ins[24:20] = 5'd0;
        drive($urandom_range(9) < 7, ins, $urandom, $urandom, $urandom,
              $urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
              $urandom, $urandom, $urandom_range(11) == 0);
    endtask

    initial begin
        rst = 1'b1;
        valid_de = 1'b0; instr_de = '0; pc_de = '0; rs1_data_de = '0; rs2_data_de = '0;
        stall = 1'b0; hazard_a = 1'b0; hazard_b = 1'b0; data_a_mgr = '0; data_b_mgr = '0;
        flush = 1'b0;
        model_reset();
        last_pc = '0; last_a = '0; last_b = '0;
        mon_en = 1'b1;
        do_reset(3);

        // First issue: addi x1,x0,5
        drive(1'b1, 32'h00500093, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // Forwarding on A: add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'h104, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 32'h0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 32'hAA, 32'h0, 1'b0);
        // x0 precedence: add x3,x0,x2
        drive(1'b1, 32'h002001B3, 32'h108, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 32'h0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 32'hDEAD, 32'h0, 1'b0);
        // Single-cycle load-use stall
        drive(1'b1, 32'h002081B3, 32'h10C, 32'h55, 32'h66, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // Three-cycle stall
        drive(1'b1, 32'h00308133, 32'h110, 32'h77, 32'h88, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (3) idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // Flush while held
        drive(1'b1, 32'h00308133, 32'h114, 32'h99, 32'hAB, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // Async reset while held
        drive(1'b1, 32'h00308133, 32'h118, 32'h12, 32'h34, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1'b1, 1'b0);
        do_reset(2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) do_reset(2);
            else rand_cycle();
        end
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
